// File: rtl/compare_monitor.sv
// compare_monitor: strobed NCHAN-channel 4-state equivalence monitor with counters, first-failure
// capture and halt-after-MAX_FAILS. Define COMPARE_MONITOR_XMASK_EN for spec-side X/Z don't-cares.
module compare_monitor #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned NCHAN     = 5,
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned MAX_FAILS = 1
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic                   i_start,
   input  logic                   i_clear,
   input  logic                   i_valid,
   input  logic [NCHAN*WIDTH-1:0] i_spec_bus,
   input  logic [NCHAN*WIDTH-1:0] i_impl_bus,
   output logic                   o_all_ok,
   output logic [NCHAN-1:0]       o_fail_mask,
   output logic [CNT_W-1:0]       o_sample_count,
   output logic [CNT_W-1:0]       o_mismatch_count,
   output logic                   o_first_valid,
   output logic [CNT_W-1:0]       o_first_index,
   output logic [NCHAN-1:0]       o_first_mask,
   output logic                   o_halted,
   output logic                   o_busy
);

   typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

   localparam logic [CNT_W-1:0] CntMax = '1;

   state_e            r_state, w_state_next;
   logic              r_all_ok, w_all_ok_next;
   logic [NCHAN-1:0]  r_fail_mask, w_fail_mask_next;
   logic [CNT_W-1:0]  r_sample_count, w_sample_count_next;
   logic [CNT_W-1:0]  r_mismatch_count, w_mismatch_count_next;
   logic              r_first_valid, w_first_valid_next;
   logic [CNT_W-1:0]  r_first_index, w_first_index_next;
   logic [NCHAN-1:0]  r_first_mask, w_first_mask_next;

   logic [NCHAN-1:0]  w_fail;
   logic              w_any_fail;
   logic              w_accept;
   logic              w_limit_hit;

   always_comb begin
      w_fail = '0;
      for (int k = 0; k < NCHAN; k++) begin
`ifdef COMPARE_MONITOR_XMASK_EN
         // Only spec bits that are a real 0/1 are checked; spec X/Z is a wildcard.
         for (int b = 0; b < WIDTH; b++) begin
            if (((i_spec_bus[k*WIDTH+b] === 1'b0) || (i_spec_bus[k*WIDTH+b] === 1'b1)) &&
                (i_impl_bus[k*WIDTH+b] !== i_spec_bus[k*WIDTH+b])) begin
               w_fail[k] = 1'b1;
            end
         end
`else
         w_fail[k] = (i_spec_bus[k*WIDTH +: WIDTH] !== i_impl_bus[k*WIDTH +: WIDTH]);
`endif
      end
   end

   assign w_any_fail = |w_fail;
   // clear wins over a coincident sample, so the sample is dropped.
   assign w_accept   = (r_state == StRun) && i_valid && !i_clear;

   always_comb begin
      w_all_ok_next         = r_all_ok;
      w_fail_mask_next      = r_fail_mask;
      w_sample_count_next   = r_sample_count;
      w_mismatch_count_next = r_mismatch_count;
      w_first_valid_next    = r_first_valid;
      w_first_index_next    = r_first_index;
      w_first_mask_next     = r_first_mask;
      w_limit_hit           = 1'b0;
      if (i_clear) begin
         w_all_ok_next         = 1'b1;
         w_fail_mask_next      = '0;
         w_sample_count_next   = '0;
         w_mismatch_count_next = '0;
         w_first_valid_next    = 1'b0;
         w_first_index_next    = '0;
         w_first_mask_next     = '0;
      end else if (w_accept) begin
         w_all_ok_next    = ~w_any_fail;
         w_fail_mask_next = w_fail;
         if (r_sample_count != CntMax) begin
            w_sample_count_next = r_sample_count + 1'b1;
         end
         if (w_any_fail) begin
            if (r_mismatch_count != CntMax) begin
               w_mismatch_count_next = r_mismatch_count + 1'b1;
            end
            w_limit_hit = (32'(w_mismatch_count_next) == MAX_FAILS);
            if (!r_first_valid) begin
               w_first_valid_next = 1'b1;
               w_first_index_next = r_sample_count;
               w_first_mask_next  = w_fail;
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:  if (i_start) w_state_next = StRun;
         StRun:   if (w_limit_hit) w_state_next = StHalt;
         StHalt:  w_state_next = StHalt;
         default: w_state_next = StIdle;
      endcase
   end

   always_comb begin
      o_busy   = (r_state == StRun);
      o_halted = (r_state == StHalt);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_all_ok         <= 1'b1;
         r_fail_mask      <= '0;
         r_sample_count   <= '0;
         r_mismatch_count <= '0;
         r_first_valid    <= 1'b0;
         r_first_index    <= '0;
         r_first_mask     <= '0;
      end else begin
         r_all_ok         <= w_all_ok_next;
         r_fail_mask      <= w_fail_mask_next;
         r_sample_count   <= w_sample_count_next;
         r_mismatch_count <= w_mismatch_count_next;
         r_first_valid    <= w_first_valid_next;
         r_first_index    <= w_first_index_next;
         r_first_mask     <= w_first_mask_next;
      end
   end

   assign o_all_ok         = r_all_ok;
   assign o_fail_mask      = r_fail_mask;
   assign o_sample_count   = r_sample_count;
   assign o_mismatch_count = r_mismatch_count;
   assign o_first_valid    = r_first_valid;
   assign o_first_index    = r_first_index;
   assign o_first_mask     = r_first_mask;

endmodule

// File: doc/compare_monitor.md
Name: compare_monitor

Overview:
- Clocked multi-channel equivalence monitor for the spec-vs-impl regression benches.
- Each strobed sample compares NCHAN channels of WIDTH bits with 4-state case equality. X and Z must match exactly.
- Counts samples and mismatches, captures the first failing sample, and halts after a programmable number of failures.
- Successor to the hard-wired five-output combinational all_ok check.

Parameters:
- WIDTH, 8: bits per channel.
- NCHAN, 5: number of compared channels.
- CNT_W, 16: width of the sample and mismatch counters.
- MAX_FAILS, 1: mismatching samples allowed before HALT. Must be ≥1.

Ports:
- clk, in, 1: sole clock, rising edge.
- reset, in, 1: synchronous, active-high.
- start, in, 1: IDLE→RUN pulse.
- clear, in, 1: synchronous soft clear of counters and capture. Does not change state.
- valid, in, 1: sample strobe. Sampled only in RUN.
- spec_bus, in, NCHAN*WIDTH: golden outputs. Channel k occupies [k*WIDTH +: WIDTH].
- impl_bus, in, NCHAN*WIDTH: implementation outputs, same packing.
- all_ok, out, 1: registered result of the last accepted sample.
- fail_mask, out, NCHAN: registered per-channel mismatch bits of the last accepted sample.
- sample_count, out, CNT_W: accepted samples.
- mismatch_count, out, CNT_W: accepted samples with at least one mismatching channel.
- first_valid, out, 1: first-failure capture is valid.
- first_index, out, CNT_W: sample_count value of the first failing sample.
- first_mask, out, NCHAN: fail_mask of the first failing sample.
- halted, out, 1: FSM is in HALT.
- busy, out, 1: FSM is in RUN.

Behaviour:
- Reset: state IDLE; all_ok=1; fail_mask=0; sample_count=0; mismatch_count=0; first_valid=0; first_index=0; first_mask=0; halted=0; busy=0.
- Reset mid-RUN or in HALT returns to IDLE the next cycle and discards the in-flight sample.
- FSM states and transitions:
  - IDLE: start=1 → RUN.
  - RUN: accepts samples. Moves to HALT at the edge where the accepted sample makes mismatch_count reach MAX_FAILS.
  - HALT: stays until reset. start is ignored.
- Acceptance: a sample is accepted at a rising edge when state==RUN and valid=1.
  - valid in IDLE or HALT is ignored; no output changes.
- Per-channel compare: fail_mask[k] = !(spec_k === impl_k).
  - Bitwise 4-state exact match: Z≠X, X≠0, Z≠Z is false, so Z===Z passes.
- Latency: 1 cycle. all_ok, fail_mask and the counters reflect sample n on the edge that accepts it, visible the following cycle.
  - all_ok = ~|fail_mask.
- sample_count increments on every accepted sample.
  - sample_count saturates at 2^CNT_W−1 and does not wrap.
- mismatch_count increments when any fail bit is set.
  - mismatch_count saturates at 2^CNT_W−1.
- First-failure capture: on the first mismatching sample while first_valid=0:
  - first_index = pre-increment sample_count, so the first sample is index 0.
  - first_mask = fail_mask.
  - first_valid = 1.
  - Later failures do not overwrite the capture.
- clear: zeroes both counters, first_valid, first_index and first_mask; sets all_ok=1 and fail_mask=0.
  - If clear and an accepted sample coincide, clear wins and the sample is dropped.
  - clear in HALT does not leave HALT.
- Simultaneous start and valid in IDLE: go to RUN; the sample is not accepted.
- halted and busy are decoded from the state register and are mutually exclusive.

Optional Feature:
- Macro: COMPARE_MONITOR_XMASK_EN.
- When defined: a spec bit of X or Z is a don't-care; fail only where the spec bit is 0/1 and impl differs (wildcard ==? semantics).
  - A spec 0/1 against an impl X/Z still fails.
- When undefined: strict === as above.

Test Plan:
- Reset, start, 4 samples with spec==impl (e.g. 8'hA5 on all 5 channels) → sample_count=4, mismatch_count=0, all_ok=1, first_valid=0, busy=1.
- MAX_FAILS=3; samples 0–2 match; sample 3 has channel 2 spec=8'h0F vs impl=8'h0E → all_ok=0, fail_mask=5'b00100, first_index=3, first_mask=5'b00100, mismatch_count=1, still RUN.
- X/Z strictness: channel 0 spec=8'bZX10_0000 vs impl=8'bXX10_0000 → fail_mask[0]=1. Identical 8'bZX10_0000 on both → pass.
  - With COMPARE_MONITOR_XMASK_EN defined: spec=8'bXXXX_0001, impl=8'b1010_0001 → pass; spec=8'h01, impl=8'b0000_000X → fail.
- MAX_FAILS=1; first mismatch on sample 0 → halted=1 next cycle; further valid samples leave sample_count=1. start has no effect. reset → IDLE with all outputs at reset values.
- CNT_W=2: 5 accepted samples → sample_count=3 (saturated). clear asserted with valid in the same cycle → counters 0, sample dropped.
- valid asserted in IDLE for 3 cycles → sample_count=0. start+valid in the same cycle → busy=1, sample_count=0.
